// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES datapath parameters and reduction-tree geometry helpers

package aes_pkg;

    localparam int NRP_WIDTH = 128;
    localparam int NRP_RADIX = 4;

    // Number of bits left after applying k levels of RADIX-wide OR nodes to w bits.
    function automatic int level_width(input int w, input int r, input int k);
        int n;
        n = w;
        for (int i = 0; i < k; i++) begin
            n = (n + r - 1) / r;
        end
        return n;
    endfunction

    function automatic int clog_radix(input int w, input int r);
        int n;
        int lv;
        n  = w;
        lv = 0;
        while (n > 1) begin
            n  = (n + r - 1) / r;
            lv = lv + 1;
        end
        if (lv < 1) begin
            lv = 1;
        end
        return lv;
    endfunction

endpackage

// File: rtl/nor_reduce_stage.sv
// rtl/nor_reduce_stage.sv - one OR-tree level (RADIX-wide nodes) with its pipeline register

module nor_reduce_stage
    import aes_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int RADIX = 4,
    parameter int TAG_W = 4,
    localparam int OUT_W = level_width(IN_W, RADIX, 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             v_i,
    input  logic [IN_W-1:0]  d_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             v_o,
    output logic [OUT_W-1:0] d_o,
    output logic [TAG_W-1:0] tag_o
);

    logic             v_d, v_q;
    logic [OUT_W-1:0] d_d, d_q;
    logic [TAG_W-1:0] tag_d, tag_q;
    logic [OUT_W-1:0] grp_or;

    // A short final group simply ORs fewer bits, which is the same as padding with 0.
    always_comb begin
        grp_or = '0;
        for (int g = 0; g < OUT_W; g++) begin
            for (int j = 0; j < RADIX; j++) begin
                if (g * RADIX + j < IN_W) begin
                    grp_or[g] = grp_or[g] | d_i[g*RADIX+j];
                end
            end
        end
    end

    always_comb begin
        v_d   = v_q;
        d_d   = d_q;
        tag_d = tag_q;
        if (en) begin
            v_d   = v_i;
            d_d   = grp_or;
            tag_d = tag_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_d;
        end
    end

    always_ff @(posedge clk) begin
        d_q   <= d_d;
        tag_q <= tag_d;
    end

    assign v_o   = v_q;
    assign d_o   = d_q;
    assign tag_o = tag_q;

endmodule

// File: rtl/nor_reduce_pipe.sv
// rtl/nor_reduce_pipe.sv - pipelined masked wide NOR/OR reduction with sticky all-zero flag

module nor_reduce_pipe
    import aes_pkg::*;
#(
    parameter int WIDTH  = NRP_WIDTH,
    parameter int RADIX  = NRP_RADIX,
    parameter int TAG_W  = 4,
    parameter int INVERT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_mask,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic             zero_seen,
    input  logic             clr_sticky
);

    localparam int   LEVELS = clog_radix(WIDTH, RADIX);
    localparam logic INV_B  = (INVERT != 0);

    logic             en;
    logic             fin_v;
    logic             fin_or;
    logic [TAG_W-1:0] fin_tag;
    logic             zero_seen_d, zero_seen_q;

    assign en       = !fin_v || out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int IN_W  = level_width(WIDTH, RADIX, k);
        localparam int OUT_W = level_width(WIDTH, RADIX, k + 1);

        logic             v;
        logic [OUT_W-1:0] d;
        logic [TAG_W-1:0] t;

        if (k == 0) begin : g_first
            nor_reduce_stage #(.IN_W(IN_W), .RADIX(RADIX), .TAG_W(TAG_W)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .v_i   (in_valid),
                .d_i   (in_data & in_mask),
                .tag_i (in_tag),
                .v_o   (v),
                .d_o   (d),
                .tag_o (t)
            );
        end else begin : g_next
            nor_reduce_stage #(.IN_W(IN_W), .RADIX(RADIX), .TAG_W(TAG_W)) u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .v_i   (g_lvl[k-1].v),
                .d_i   (g_lvl[k-1].d),
                .tag_i (g_lvl[k-1].t),
                .v_o   (v),
                .d_o   (d),
                .tag_o (t)
            );
        end
    end

    assign fin_v   = g_lvl[LEVELS-1].v;
    assign fin_or  = g_lvl[LEVELS-1].d[0];
    assign fin_tag = g_lvl[LEVELS-1].t;

    // Data flops are not reset, so outputs are gated by valid to read 0 out of reset.
    assign out_valid = fin_v;
    assign out_res   = fin_v & (fin_or ^ INV_B);
    assign out_tag   = fin_v ? fin_tag : '0;

    always_comb begin
        zero_seen_d = zero_seen_q;
        if (fin_v && out_ready && !fin_or) begin
            zero_seen_d = 1'b1;
        end else if (clr_sticky) begin
            zero_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_seen_q <= 1'b0;
        end else begin
            zero_seen_q <= zero_seen_d;
        end
    end

    assign zero_seen = zero_seen_q;

endmodule
